mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Arbitrates the single byte-wide RAM port between instruction fetch (IF, word reads) and MEM stage (byte/half/word loads and stores).
//  Serialises each access into per-byte RAM cycles, assembles and sign/zero-extends read data, and returns a one-cycle done pulse to the owning requester.
//  Sits between the IF/MEM stages and the RAM model, replacing per-stage byte sequencing.
// PARAMETERS
//  ADDR_WIDTH  32  width of all address ports (RAM and requesters)
// PORTS
//  clk            in   1           clock; all state changes on rising edge
//  rst            in   1           reset, synchronous, active-high
//  if_req_i       in   1           IF read request, held until if_done_o
//  if_addr_i      in   ADDR_WIDTH  IF word address
//  if_flush_i     in   1           abort pending/in-flight IF read
//  if_done_o      out  1           one-cycle pulse: if_data_o valid
//  if_data_o      out  32          fetched word, little-endian
//  mem_req_i      in   1           MEM request, held until mem_done_o
//  mem_we_i       in   1           1 = store, 0 = load
//  mem_sel_i      in   `MemSelBus  `MEM_BYTE / `MEM_HALF / `MEM_WORD
//  mem_sign_i     in   1           load: 1 = sign-extend, 0 = zero-extend
//  mem_addr_i     in   ADDR_WIDTH  byte address of lowest byte
//  mem_wdata_i    in   32          store data, bits [7:0] written first
//  mem_done_o     out  1           one-cycle pulse: access complete
//  mem_rdata_o    out  32          extended load data, valid with mem_done_o
//  ram_addr_o     out  ADDR_WIDTH  RAM byte address
//  ram_wr_o       out  1           RAM write strobe
//  ram_dout_o     out  8           RAM write byte
//  ram_din_i      in   8           RAM read byte; reflects ram_addr_o of previous cycle
// BEHAVIOUR
//  Reset: ram_wr_o=0, ram_addr_o=0, ram_dout_o=0, if_done_o=0, mem_done_o=0, if_data_o=0, mem_rdata_o=0, state=IDLE, counters=0. Reset mid-access drops it; no done is issued; ram_wr_o is 0 from the next cycle.
//  All outputs registered. Byte count n: BYTE=1, HALF=2, WORD=4 (IF always 4). `MEM_NOP with mem_req_i is ignored.
//  FSM states: IDLE, READ, WRITE, DONE.
//  IDLE:
//   - mem_req_i is granted before if_req_i (fixed MEM priority); no preemption once granted.
//   - On grant, latch owner, addr, sel, sign and wdata. Go to READ or WRITE with cnt=0.
//   - if_req_i is not granted in a cycle where if_flush_i=1.
//  READ (accept edge = cycle 0):
//   - ram_addr_o = addr+k in cycle k+1, k=0..n-1.
//   - Byte k is captured from ram_din_i at the end of cycle k+2.
//   - After the last capture, go to DONE. Owner done is high in cycle n+2: WORD in cycle 6, BYTE in cycle 3.
//  WRITE:
//   - ram_wr_o=1, ram_addr_o=addr+k, ram_dout_o=wdata[8k+7:8k] in cycle k+1.
//   - ram_wr_o drops in cycle n+1. mem_done_o is high in cycle n+1, state DONE.
//  DONE: holds for exactly one cycle with the owner's done=1, then returns to IDLE. Requests are not sampled in DONE, so a still-high req is not re-granted; the requester drops req or issues a new request the cycle after done.
//  Extension: BYTE gives {{24{s&b0[7]}},b0}; HALF gives {{16{s&b1[7]}},b1,b0}; WORD gives {b3,b2,b1,b0}.
//  Data hold: if_data_o and mem_rdata_o keep their last value outside done.
//  if_flush_i while owner=IF in READ: next state IDLE, no if_done_o, RAM reads discarded. Flush never affects a MEM-owned access.
//  Address increment wraps modulo 2^ADDR_WIDTH. No alignment check; misaligned accesses are performed bytewise.
//  Simultaneous if_req_i and mem_req_i in IDLE: MEM wins; IF waits with req held.
// STRUCTURE
//  Selector codes `MEM_BYTE/`MEM_HALF/`MEM_WORD/`MEM_NOP and `MemSelBus come from defines.v. Add `CtrlStateBus and the four state encodings there.
//  Single module, no sub-module; byte assembly and extension are inline.
// TESTING
//  1. IF req addr 0x100, RAM[0x100..0x103]=11,22,33,44 -> if_data_o=0x44332211, if_done_o in cycle 6, single pulse.
//  2. MEM store word 0xDEADBEEF @0x20 -> ram_wr_o cycles 1-4, bytes EF,BE,AD,DE at 0x20-0x23, mem_done_o cycle 5.
//  3. MEM LB sign=1 @0x30 (RAM=0x80) -> 0xFFFFFF80; LHU @0x30 (0x80,0xFF) -> 0x0000FF80.
//  4. IF and MEM req same cycle -> MEM served first; IF granted in the IDLE cycle after MEM's DONE.
//  5. IF read in flight, if_flush_i in cycle 2 -> no if_done_o, IDLE in cycle 3; a pending MEM req is granted next.
//  6. rst high in cycle 2 of a word store -> ram_wr_o=0 from cycle 3, no mem_done_o; a later access completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types, selector codes and load helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  // Width of the MEM access-size selector.
  localparam int MEM_SEL_W = 2;

  // Access-size selector codes.
  localparam logic [MEM_SEL_W-1:0] MEM_NOP  = 2'd0;
  localparam logic [MEM_SEL_W-1:0] MEM_BYTE = 2'd1;
  localparam logic [MEM_SEL_W-1:0] MEM_HALF = 2'd2;
  localparam logic [MEM_SEL_W-1:0] MEM_WORD = 2'd3;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  // Which requester currently owns the RAM port.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Number of RAM byte cycles for an access size.
  function automatic logic [2:0] byte_count(input logic [MEM_SEL_W-1:0] sel);
    case (sel)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  // Sign/zero-extend the assembled little-endian bytes to 32 bits.
  function automatic logic [31:0] extend_load(input logic [MEM_SEL_W-1:0] sel,
                                              input logic sign,
                                              input logic [31:0] raw);
    case (sel)
      MEM_BYTE: return {{24{sign & raw[7]}}, raw[7:0]};
      MEM_HALF: return {{16{sign & raw[15]}}, raw[15:0]};
      default:  return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for the IF (word fetch) and MEM (load/store) stages.
// MEM has fixed priority; each access is split into per-byte RAM cycles and a
// single-cycle done pulse is returned to the requester that owned the port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_data_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [MEM_SEL_W-1:0]  mem_sel_i,
  input  logic                  mem_sign_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  ctrl_state_t           state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_SEL_W-1:0]  sel_q, sel_d;
  logic                  sign_q, sign_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  logic [2:0]            n_s;
  logic [2:0]            inc_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [31:0]           full_s;

  assign n_s         = byte_count(sel_q);
  assign inc_s       = cnt_q + 3'd1;
  assign next_addr_s = addr_q + {{(ADDR_WIDTH-3){1'b0}}, inc_s};

  // Merge the byte arriving this cycle (index cnt-1) into the read buffer.
  always_comb begin
    full_s = buf_q;
    case (cnt_q)
      3'd1:    full_s[7:0]   = ram_din_i;
      3'd2:    full_s[15:8]  = ram_din_i;
      3'd3:    full_s[23:16] = ram_din_i;
      3'd4:    full_s[31:24] = ram_din_i;
      default: full_s = buf_q;
    endcase
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i && (mem_sel_i != MEM_NOP)) begin
          owner_d    = OWN_MEM;
          addr_d     = mem_addr_i;
          sel_d      = mem_sel_i;
          sign_d     = mem_sign_i;
          wdata_d    = mem_wdata_i;
          cnt_d      = 3'd0;
          buf_d      = 32'h0000_0000;
          ram_addr_d = mem_addr_i;
          if (mem_we_i) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
            state_d    = ST_WRITE;
          end else begin
            state_d    = ST_READ;
          end
        end else if (if_req_i && !if_flush_i) begin
          owner_d    = OWN_IF;
          addr_d     = if_addr_i;
          sel_d      = MEM_WORD;
          sign_d     = 1'b0;
          cnt_d      = 3'd0;
          buf_d      = 32'h0000_0000;
          ram_addr_d = if_addr_i;
          state_d    = ST_READ;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        if ((owner_q == OWN_IF) && if_flush_i) begin
          // Abandon the fetch; bytes already on their way are simply dropped.
          state_d = ST_IDLE;
        end else if (cnt_q == n_s) begin
          state_d = ST_DONE;
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
            if_data_d = full_s;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = extend_load(sel_q, sign_q, full_s);
          end
        end else begin
          buf_d = full_s;
          cnt_d = inc_s;
          if (inc_s < n_s) begin
            ram_addr_d = next_addr_s;
          end else begin
            ram_addr_d = ram_addr_q;
          end
        end
      end
      ST_WRITE: begin
        if (inc_s < n_s) begin
          cnt_d      = inc_s;
          ram_wr_d   = 1'b1;
          ram_addr_d = next_addr_s;
          ram_dout_d = wdata_q[15:8];
          wdata_d    = {8'h00, wdata_q[31:8]};
        end else begin
          mem_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are deliberately not sampled here so a held req is not re-granted.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      sel_q       <= MEM_NOP;
      sign_q      <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      cnt_q       <= 3'd0;
      buf_q       <= 32'h0000_0000;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'h0000_0000;
      mem_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_dout_o  = ram_dout_q;
  assign if_done_o   = if_done_q;
  assign if_data_o   = if_data_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized accesses
// compared against a byte-array reference memory and cycle-count rules.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_data_o;
  logic        mem_req_i, mem_we_i, mem_sign_i, mem_done_o;
  logic [1:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  logic [7:0]  ram [0:1023];
  logic        ram_init, pk_en;
  logic [9:0]  pk_addr;
  logic [7:0]  pk_data;
  logic [7:0]  exp_mem [0:1023];
  int          n_cmp = 0;
  int          n_err = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_sign_i(mem_sign_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // 1 KiB RAM model (address taken modulo 1024), one-cycle read latency.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 37 + 5);
    end else begin
      if (ram_wr_o) ram[ram_addr_o[9:0]] <= ram_dout_o;
      if (pk_en) ram[pk_addr] <= pk_data;
    end
    ram_din_i <= ram[ram_addr_o[9:0]];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sel_n(input logic [1:0] s);
    if (s == MEM_BYTE) return 1;
    if (s == MEM_HALF) return 2;
    return 4;
  endfunction

  // Reference load: little-endian bytes from the model memory, then extension.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit s);
    logic [63:0] v;
    logic [31:0] ak;
    v = 64'd0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      v = v + (64'(exp_mem[ak[9:0]]) << (8 * k));
    end
    if (s && (v >= (64'd1 << (8 * n - 1)))) v = v + (~64'd0 << (8 * n));
    return v[31:0];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_addr = a[9:0]; pk_data = d; exp_mem[a[9:0]] = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // One access started at a negedge with the DUT idle (cycle 0); returns at the idle cycle after done.
  task automatic run_access(input bit is_if, input bit we, input logic [1:0] sel, input bit sign,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] got);
    int n, ed;
    bit seen;
    logic [31:0] expd, a;
    n = is_if ? 4 : sel_n(sel);
    ed = we ? n + 1 : n + 2;
    expd = we ? 32'h0 : model_load(addr, n, is_if ? 1'b0 : sign);
    seen = 1'b0;
    got = 32'h0;
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_sign_i = sign;
      mem_addr_i = addr; mem_wdata_i = wdata;
    end
    for (int c = 1; c <= 14 && !seen; c++) begin
      @(negedge clk);
      if (c <= n) begin
        chk("ram_addr", ram_addr_o, addr + 32'(c - 1));
        if (we) begin
          chk("ram_wr", 32'(ram_wr_o), 32'd1);
          chk("ram_dout", 32'(ram_dout_o), (wdata >> (8 * (c - 1))) & 32'hFF);
        end
      end
      if (we && c == n + 1) chk("ram_wr_drop", 32'(ram_wr_o), 32'd0);
      if (is_if ? if_done_o : mem_done_o) begin
        seen = 1'b1;
        chk("done_cycle", 32'(c), 32'(ed));
        chk("other_done", 32'(is_if ? mem_done_o : if_done_o), 32'd0);
        got = is_if ? if_data_o : mem_rdata_o;
        if (!we) chk("rdata", got, expd);
        if_req_i = 1'b0; mem_req_i = 1'b0;
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      if_req_i = 1'b0; mem_req_i = 1'b0;
    end
    if (we) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        exp_mem[a[9:0]] = 8'((wdata >> (8 * k)) & 32'hFF);
      end
    end
    @(negedge clk);
    chk("single_pulse", 32'(is_if ? if_done_o : mem_done_o), 32'd0);
    if (!we && seen) chk("data_hold", is_if ? if_data_o : mem_rdata_o, got);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    bit seen_if, seen_mem;
    int mem_cyc;
    rst = 1'b1; ram_init = 1'b1; pk_en = 1'b0; pk_addr = 10'd0; pk_data = 8'h00;
    if_req_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = MEM_NOP; mem_sign_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 8'(i * 37 + 5);
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    chk("rst_ram_wr", 32'(ram_wr_o), 32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    chk("rst_ram_dout", 32'(ram_dout_o), 32'd0);
    chk("rst_if_done", 32'(if_done_o), 32'd0);
    chk("rst_mem_done", 32'(mem_done_o), 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_mem_rdata", mem_rdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word fetch
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    run_access(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, d);
    chk("t1_word", d, 32'h4433_2211);

    // Word store
    run_access(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF, d);
    chk("t2_ram", {ram[10'h23], ram[10'h22], ram[10'h21], ram[10'h20]}, 32'hDEAD_BEEF);

    // Signed / unsigned byte and half loads
    poke(32'h30, 8'h80); poke(32'h31, 8'hFF);
    run_access(1'b0, 1'b0, MEM_BYTE, 1'b1, 32'h30, 32'h0, d);
    chk("t3_lb", d, 32'hFFFF_FF80);
    run_access(1'b0, 1'b0, MEM_HALF, 1'b0, 32'h30, 32'h0, d);
    chk("t3_lhu", d, 32'h0000_FF80);
    run_access(1'b0, 1'b0, MEM_HALF, 1'b1, 32'h30, 32'h0, d);
    chk("t3_lh", d, 32'hFFFF_FF80);
    run_access(1'b0, 1'b0, MEM_BYTE, 1'b0, 32'h30, 32'h0, d);
    chk("t3_lbu", d, 32'h0000_0080);

    // Simultaneous requests: MEM first, IF granted in the idle cycle after MEM's done
    seen_if = 1'b0; seen_mem = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = MEM_BYTE; mem_sign_i = 1'b1; mem_addr_i = 32'h30;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int c = 1; c <= 14 && !seen_if; c++) begin
      @(negedge clk);
      if (c == 5) chk("t4_if_addr", ram_addr_o, 32'h100);
      if (mem_done_o) begin
        seen_mem = 1'b1;
        chk("t4_mem_cyc", 32'(c), 32'd3);
        chk("t4_mem_data", mem_rdata_o, 32'hFFFF_FF80);
        mem_req_i = 1'b0;
      end
      if (if_done_o) begin
        seen_if = 1'b1;
        chk("t4_if_cyc", 32'(c), 32'd10);
        chk("t4_if_data", if_data_o, 32'h4433_2211);
        if_req_i = 1'b0;
      end
    end
    chk("t4_both_seen", {30'd0, seen_if, seen_mem}, 32'd3);
    if_req_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);

    // Flush of an in-flight fetch; pending MEM store granted next
    seen_if = 1'b0; mem_cyc = 0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (if_done_o) seen_if = 1'b1;
      if (mem_done_o && mem_cyc == 0) begin mem_cyc = c; mem_req_i = 1'b0; end
      if (c == 1) begin
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = MEM_BYTE; mem_addr_i = 32'h40; mem_wdata_i = 32'h0000_005A;
      end
      if (c == 2) begin if_flush_i = 1'b1; if_req_i = 1'b0; end
      if (c == 3) if_flush_i = 1'b0;
      if (c == 4) begin
        chk("t5_wr", 32'(ram_wr_o), 32'd1);
        chk("t5_addr", ram_addr_o, 32'h40);
        chk("t5_dout", 32'(ram_dout_o), 32'h5A);
      end
    end
    chk("t5_no_if_done", 32'(seen_if), 32'd0);
    chk("t5_mem_cyc", 32'(mem_cyc), 32'd5);
    mem_req_i = 1'b0;
    exp_mem[10'h40] = 8'h5A;

    // MEM request with NOP selector is ignored; IF is served
    seen_mem = 1'b0; seen_if = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = MEM_NOP; mem_addr_i = 32'h30;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int c = 1; c <= 12 && !seen_if; c++) begin
      @(negedge clk);
      if (mem_done_o) seen_mem = 1'b1;
      if (if_done_o) begin seen_if = 1'b1; chk("nop_if_cyc", 32'(c), 32'd6); end
    end
    chk("nop_if_seen", 32'(seen_if), 32'd1);
    chk("nop_no_mem", 32'(seen_mem), 32'd0);
    mem_req_i = 1'b0; if_req_i = 1'b0;
    @(negedge clk);

    // Reset in cycle 2 of a word store
    seen_mem = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = MEM_WORD; mem_addr_i = 32'h50; mem_wdata_i = 32'hCAFE_F00D;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_done_o) seen_mem = 1'b1;
      if (c == 2) begin rst = 1'b1; mem_req_i = 1'b0; end
      if (c >= 3) chk("t6_wr_low", 32'(ram_wr_o), 32'd0);
      if (c == 3) begin
        rst = 1'b0;
        chk("t6_rst_addr", ram_addr_o, 32'd0);
        chk("t6_rst_if_data", if_data_o, 32'd0);
        chk("t6_rst_rdata", mem_rdata_o, 32'd0);
      end
    end
    chk("t6_no_done", 32'(seen_mem), 32'd0);
    exp_mem[10'h50] = 8'h0D; exp_mem[10'h51] = 8'hF0;
    run_access(1'b0, 1'b0, MEM_WORD, 1'b0, 32'h50, 32'h0, d);

    // Address wrap
    run_access(1'b0, 1'b1, MEM_WORD, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, d);
    run_access(1'b1, 1'b0, MEM_WORD, 1'b0, 32'hFFFF_FFFE, 32'h0, d);
    chk("wrap_word", d, 32'h1234_5678);

    // Randomized accesses against the reference memory
    for (int it = 0; it < 40; it++) begin
      bit rif, rwe, rsg;
      logic [1:0] rsel;
      rif = ($urandom_range(0, 2) == 0);
      rwe = !rif && ($urandom_range(0, 1) == 1);
      rsel = rif ? MEM_WORD : 2'($urandom_range(1, 3));
      rsg = ($urandom_range(0, 1) == 1);
      a = $urandom;
      run_access(rif, rwe, rsel, rsg, a, $urandom, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
